// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, ROM request issue, prefetch FIFO and valid/ready delivery to decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect halts fetch and presents a fault entry.
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instruction,
  output logic            out_fault
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] fetch_pc, inflight_pc, halt_pc, target;
  logic [XLEN-1:0] pc_mem [FIFO_DEPTH];
  logic [31:0] ins_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, occ;
  logic inflight, push, pop, misaligned, has_head;
`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = redirect_pc[1:0] != 2'b00;
  assign target = redirect_pc;
`else
  assign misaligned = 1'b0;
  assign target = redirect_pc & ~XLEN'(3);
`endif
  assign imem_addr = fetch_pc;
  assign occ = count + (AW+1)'(inflight);
  assign has_head = state == RUN && count != '0;
  // A redirect drops the response still in flight by suppressing its push.
  always_comb begin
    state_n = redirect_valid ? (misaligned ? HALT : RUN) : state;
    imem_req = !rst && state == RUN && !redirect_valid && occ < (AW+1)'(FIFO_DEPTH);
    push = inflight && !redirect_valid;
    pop = has_head && out_ready && !redirect_valid;
    out_valid = state == HALT || has_head;
    out_fault = state == HALT;
    out_pc = state == HALT ? halt_pc : (has_head ? pc_mem[rd_ptr] : '0);
    out_instruction = has_head ? ins_mem[rd_ptr] : '0;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= inflight_pc;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      halt_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      inflight <= imem_req;
      if (imem_req) inflight_pc <= fetch_pc;
      if (redirect_valid) begin
        fetch_pc <= target;
        halt_pc <= target;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        if (imem_req) fetch_pc <= fetch_pc + XLEN'(4);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle vectors plus hand sequences for stalls, redirects and faults.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst, redirect_valid, imem_req, out_valid, out_ready, out_fault;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, out_pc, out_instruction;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic rst, rv;
    logic [31:0] rpc;
    logic rdy, req;
    logic [31:0] addr;
    logic v;
    logic [31:0] pc, ins;
  } vec_t;
  vec_t tbl[$];
  fetch_unit #(.XLEN(32), .RESET_PC(32'h100), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instruction(out_instruction), .out_fault(out_fault)
  );
  always #5 clk = ~clk;
  // ROM model: word i holds i, one-cycle read latency.
  always @(posedge clk) imem_rdata <= {2'b00, imem_addr[31:2]};
  function automatic vec_t mk(logic r, logic rv, logic [31:0] rpc, logic rdy, logic req,
                              logic [31:0] addr, logic v, logic [31:0] pc, logic [31:0] ins);
    vec_t t;
    t.rst = r; t.rv = rv; t.rpc = rpc; t.rdy = rdy; t.req = req;
    t.addr = addr; t.v = v; t.pc = pc; t.ins = ins;
    return t;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic drive(logic r, logic rv, logic [31:0] rpc, logic rdy);
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    #1;
  endtask
  task automatic run_row(vec_t t, string tag);
    drive(t.rst, t.rv, t.rpc, t.rdy);
    chk({tag, " imem_req"}, 64'(imem_req), 64'(t.req));
    chk({tag, " imem_addr"}, 64'(imem_addr), 64'(t.addr));
    chk({tag, " out_valid"}, 64'(out_valid), 64'(t.v));
    chk({tag, " out_pc"}, 64'(out_pc), 64'(t.pc));
    chk({tag, " out_instruction"}, 64'(out_instruction), 64'(t.ins));
    chk({tag, " out_fault"}, 64'(out_fault), 64'(0));
  endtask
  initial begin
    logic [31:0] exp_pc, prev_pc;
    logic prev_hold;
    int n;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    tbl.push_back(mk(1,0,0,1, 0,'h100,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,'h100,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,'h104,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,'h108,1,'h100,'h40));
    tbl.push_back(mk(0,0,0,1, 1,'h10C,1,'h104,'h41));
    tbl.push_back(mk(1,0,0,1, 0,'h110,1,'h108,'h42));
    tbl.push_back(mk(1,0,0,1, 0,'h100,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,'h100,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,'h104,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,'h108,1,'h100,'h40));
    tbl.push_back(mk(0,0,0,0, 1,'h10C,1,'h100,'h40));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0,0,0,0, 0,'h110,1,'h100,'h40));
    tbl.push_back(mk(0,0,0,1, 0,'h110,1,'h100,'h40));
    tbl.push_back(mk(0,0,0,1, 1,'h110,1,'h104,'h41));
    tbl.push_back(mk(0,0,0,1, 1,'h114,1,'h108,'h42));
    tbl.push_back(mk(0,0,0,1, 1,'h118,1,'h10C,'h43));
    tbl.push_back(mk(0,0,0,1, 1,'h11C,1,'h110,'h44));
    tbl.push_back(mk(0,0,0,0, 1,'h120,1,'h114,'h45));
    tbl.push_back(mk(0,1,'h200,0, 0,'h124,1,'h114,'h45));
    tbl.push_back(mk(0,0,0,1, 1,'h200,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,'h204,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,'h208,1,'h200,'h80));
    tbl.push_back(mk(0,0,0,1, 1,'h20C,1,'h204,'h81));
    tbl.push_back(mk(0,1,'h300,1, 0,'h210,1,'h208,'h82));
    tbl.push_back(mk(0,1,'h400,1, 0,'h300,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,'h400,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,'h404,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,'h408,1,'h400,'h100));
    tbl.push_back(mk(0,0,0,1, 1,'h40C,1,'h404,'h101));
`ifndef FETCH_ALIGN_CHECK_EN
    tbl.push_back(mk(0,1,'h502,1, 0,'h410,1,'h408,'h102));
    tbl.push_back(mk(0,0,0,1, 1,'h500,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,'h504,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,'h508,1,'h500,'h140));
`endif
    foreach (tbl[i]) run_row(tbl[i], $sformatf("row%0d", i));
    // Random backpressure: in-order stream with no gaps/dups and stable stalled outputs.
    drive(0, 1, 32'h600, 1);
    exp_pc = 32'h600; prev_hold = 1'b0; prev_pc = '0; n = 0;
    for (int c = 0; c < 300; c++) begin
      drive(0, 0, 0, 1'($urandom_range(0, 1)));
      if (prev_hold) begin
        chk("stall out_valid", 64'(out_valid), 64'(1));
        chk("stall out_pc", 64'(out_pc), 64'(prev_pc));
      end
      if (out_valid && out_ready) begin
        chk("stream out_pc", 64'(out_pc), 64'(exp_pc));
        chk("stream out_instruction", 64'(out_instruction), 64'(exp_pc >> 2));
        exp_pc += 4;
        n++;
      end
      prev_hold = out_valid && !out_ready;
      prev_pc = out_pc;
    end
    chk("stream transfers>=50", 64'(n >= 50), 64'(1));
`ifdef FETCH_ALIGN_CHECK_EN
    drive(0, 1, 32'h202, 1);
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 0, 1);
      chk("halt imem_req", 64'(imem_req), 64'(0));
      chk("halt out_valid", 64'(out_valid), 64'(1));
      chk("halt out_fault", 64'(out_fault), 64'(1));
      chk("halt out_pc", 64'(out_pc), 64'h202);
      chk("halt out_instruction", 64'(out_instruction), 64'(0));
    end
    drive(0, 1, 32'h300, 1);
    chk("unhalt redirect imem_req", 64'(imem_req), 64'(0));
    run_row(mk(0,0,0,1, 1,'h300,0,0,0), "unhalt0");
    run_row(mk(0,0,0,1, 1,'h304,0,0,0), "unhalt1");
    run_row(mk(0,0,0,1, 1,'h308,1,'h300,'hC0), "unhalt2");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
